// File: rtl/fpu_seq_ctrl.sv
// Sequencer/scoreboard for a multi-cycle FP unit: one op in flight, per-op latency
// countdown, writeback strobe, busy-register hazard detection and sticky exception flags.
module fpu_seq_ctrl #(
  parameter int unsigned LAT_ADD   = 2,
  parameter int unsigned LAT_MUL   = 3,
  parameter int unsigned LAT_DIV   = 8,
  parameter int unsigned DBL_EXTRA = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic       req_dbl,
  input  logic [4:0] req_fd,
  output logic       req_stall,
  input  logic       chk_rd_en,
  input  logic [4:0] chk_rd_a,
  input  logic [4:0] chk_rd_b,
  input  logic       chk_wr_en,
  input  logic [4:0] chk_wr,
  output logic       chk_stall,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       fpu_dbl,
  input  logic [7:0] fpu_status,
  output logic       wb_en,
  output logic [4:0] wb_fd,
  output logic       wb_dbl,
  input  logic       clr_flags,
  output logic [7:0] sticky_flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_lat;
  logic        w_accept;
  logic [31:0] r_busy;
  logic [1:0]  r_op;
  logic        r_dbl;
  logic [4:0]  r_fd;
  logic [7:0]  r_sticky;

  function automatic logic [3:0] f_lat(input logic [1:0] op, input logic dbl);
    int unsigned l;
    case (op)
      2'b00, 2'b01: l = LAT_ADD;
      2'b10:        l = LAT_MUL;
      default:      l = LAT_DIV;
    endcase
    if (dbl) l = l + DBL_EXTRA;
    if (l > 15) l = 15;
    return 4'(l);
  endfunction

  // A double occupies fd and fd+1; the 5-bit increment wraps 31 -> 0.
  function automatic logic [31:0] f_mask(input logic [4:0] fd, input logic dbl);
    logic [31:0] m;
    logic [4:0]  nx;
    m     = '0;
    nx    = fd + 5'd1;
    m[fd] = 1'b1;
    if (dbl) m[nx] = 1'b1;
    return m;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_lat       = f_lat(req_op, req_dbl);
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_lat <= 4'd1) begin
            w_state_nxt = S_WB;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = w_lat - 4'd1;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_WB;
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= '0;
      r_op     <= '0;
      r_dbl    <= 1'b0;
      r_fd     <= '0;
      r_sticky <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op   <= req_op;
        r_dbl  <= req_dbl;
        r_fd   <= req_fd;
        r_busy <= r_busy | f_mask(req_fd, req_dbl);
      end else if (r_state == S_WB) begin
        r_busy <= r_busy & ~f_mask(r_fd, r_dbl);
      end
      if (clr_flags)              r_sticky <= '0;
      else if (r_state == S_WB)   r_sticky <= r_sticky | fpu_status;
    end
  end

  assign fpu_start    = w_accept & rst_n;
  assign req_stall    = req_valid & (r_state != S_IDLE);
  assign wb_en        = (r_state == S_WB);
  assign fpu_op       = r_op;
  assign fpu_dbl      = r_dbl;
  assign wb_fd        = r_fd;
  assign wb_dbl       = r_dbl;
  assign sticky_flags = r_sticky;
  assign chk_stall    = (chk_rd_en & (r_busy[chk_rd_a] | r_busy[chk_rd_b]))
                      | (chk_wr_en & r_busy[chk_wr]);

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: directed scenarios plus randomized traffic checked against
// a countdown-based transaction model; a second instance covers the latency-1 add case.
module tb_fpu_seq_ctrl;
  localparam int LAT_ADD = 2, LAT_MUL = 3, LAT_DIV = 8, DBL_EXTRA = 1;

  logic clk, rst_n, req_valid, req_dbl, chk_rd_en, chk_wr_en, clr_flags;
  logic [1:0] req_op;
  logic [4:0] req_fd, chk_rd_a, chk_rd_b, chk_wr;
  logic [7:0] fpu_status;

  logic req_stall, chk_stall, fpu_start, fpu_dbl, wb_en, wb_dbl;
  logic [1:0] fpu_op;
  logic [4:0] wb_fd;
  logic [7:0] sticky_flags;

  logic req_stall_1, chk_stall_1, fpu_start_1, fpu_dbl_1, wb_en_1, wb_dbl_1;
  logic [1:0] fpu_op_1;
  logic [4:0] wb_fd_1;
  logic [7:0] sticky_flags_1;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_seq_ctrl #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .DBL_EXTRA(DBL_EXTRA)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_dbl(req_dbl),
    .req_fd(req_fd), .req_stall(req_stall), .chk_rd_en(chk_rd_en), .chk_rd_a(chk_rd_a),
    .chk_rd_b(chk_rd_b), .chk_wr_en(chk_wr_en), .chk_wr(chk_wr), .chk_stall(chk_stall),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_dbl(fpu_dbl), .fpu_status(fpu_status),
    .wb_en(wb_en), .wb_fd(wb_fd), .wb_dbl(wb_dbl), .clr_flags(clr_flags),
    .sticky_flags(sticky_flags));

  fpu_seq_ctrl #(.LAT_ADD(1), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .DBL_EXTRA(DBL_EXTRA)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_dbl(req_dbl),
    .req_fd(req_fd), .req_stall(req_stall_1), .chk_rd_en(chk_rd_en), .chk_rd_a(chk_rd_a),
    .chk_rd_b(chk_rd_b), .chk_wr_en(chk_wr_en), .chk_wr(chk_wr), .chk_stall(chk_stall_1),
    .fpu_start(fpu_start_1), .fpu_op(fpu_op_1), .fpu_dbl(fpu_dbl_1), .fpu_status(fpu_status),
    .wb_en(wb_en_1), .wb_fd(wb_fd_1), .wb_dbl(wb_dbl_1), .clr_flags(clr_flags),
    .sticky_flags(sticky_flags_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: one op in flight, m_left counts cycles remaining until its writeback cycle.
  bit [31:0] m_busy;
  bit        m_active;
  int        m_left;
  bit [1:0]  m_op;
  bit        m_dbl;
  bit [4:0]  m_fd;
  bit [7:0]  m_sticky;

  function automatic int lat_of(input bit [1:0] op, input bit dbl);
    int l;
    l = (op == 2) ? LAT_MUL : (op == 3) ? LAT_DIV : LAT_ADD;
    if (dbl) l += DBL_EXTRA;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic bit e_chk();
    return (chk_rd_en && (m_busy[chk_rd_a] || m_busy[chk_rd_b])) || (chk_wr_en && m_busy[chk_wr]);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_active = 0; m_left = 0; m_op = 0; m_dbl = 0; m_fd = 0; m_sticky = 0;
  endtask

  task automatic model_advance();
    bit wb;
    if (!rst_n) begin model_reset(); return; end
    wb = m_active && (m_left == 0);
    if (clr_flags) m_sticky = 0;
    else if (wb) m_sticky |= fpu_status;
    if (m_active) begin
      if (m_left == 0) begin
        m_busy[m_fd] = 0;
        if (m_dbl) m_busy[(int'(m_fd) + 1) % 32] = 0;
        m_active = 0;
      end else m_left--;
    end else if (req_valid) begin
      m_active = 1; m_left = lat_of(req_op, req_dbl) - 1;
      m_op = req_op; m_dbl = req_dbl; m_fd = req_fd;
      m_busy[m_fd] = 1;
      if (m_dbl) m_busy[(int'(m_fd) + 1) % 32] = 1;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_op = 0; req_dbl = 0; req_fd = 0;
    chk_rd_en = 0; chk_rd_a = 0; chk_rd_b = 0; chk_wr_en = 0; chk_wr = 0;
    fpu_status = 0; clr_flags = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && m_active; i++) adv();
    adv();
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = 1; req_fd = 5'd3;
    rst_n = 0; model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({req_stall, chk_stall, fpu_start, wb_en, fpu_op, fpu_dbl, wb_fd, wb_dbl, sticky_flags} !== '0) begin
        n_fail++; $display("FAIL reset_outputs cyc%0d got st=%b cs=%b fs=%b wb=%b op=%h fd=%h sf=%h exp all 0",
          c, req_stall, chk_stall, fpu_start, wb_en, fpu_op, wb_fd, sticky_flags);
      end
      adv();
    end
    rst_n = 1; idle_inputs();
    chk_rd_en = 1; chk_rd_a = 5'd5; chk_rd_b = 5'd5;
    @(negedge clk);
    n_tests++;
    if (chk_stall !== 1'b0) begin n_fail++; $display("FAIL reset_chk_stall got %b exp 0", chk_stall); end
    adv();
    idle_inputs();
  endtask

  task automatic test_single_add();
    req_valid = 1; req_op = 2'b00; req_dbl = 0; req_fd = 5'd4;
    @(negedge clk);
    n_tests++;
    if (fpu_start !== 1'b1 || req_stall !== 1'b0) begin
      n_fail++; $display("FAIL add_start got fs=%b st=%b exp fs=1 st=0", fpu_start, req_stall);
    end
    adv();
    req_valid = 0; chk_rd_en = 1; chk_rd_a = 5'd4; chk_rd_b = 5'd9;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (chk_stall !== (c <= 2)) begin n_fail++; $display("FAIL add_chk_stall cyc%0d got %b exp %b", c, chk_stall, c <= 2); end
      n_tests++;
      if (wb_en !== (c == 2)) begin n_fail++; $display("FAIL add_wb_en cyc%0d got %b exp %b", c, wb_en, c == 2); end
      if (c == 2) begin
        n_tests++;
        if (wb_fd !== 5'd4 || wb_dbl !== 1'b0) begin
          n_fail++; $display("FAIL add_wb_fd got fd=%0d dbl=%b exp fd=4 dbl=0", wb_fd, wb_dbl);
        end
      end
      adv();
    end
    drain();
  endtask

  task automatic test_double_div();
    req_valid = 1; req_op = 2'b11; req_dbl = 1; req_fd = 5'd31;
    @(negedge clk);
    n_tests++;
    if (fpu_start !== 1'b1) begin n_fail++; $display("FAIL div_start got %b exp 1", fpu_start); end
    adv();
    req_op = 2'b00; req_dbl = 0; req_fd = 5'd2;
    chk_wr_en = 1; chk_wr = 5'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_tests++;
      if (req_stall !== 1'b1 || fpu_start !== 1'b0) begin
        n_fail++; $display("FAIL div_req_stall cyc%0d got st=%b fs=%b exp st=1 fs=0", c, req_stall, fpu_start);
      end
      n_tests++;
      if (chk_stall !== 1'b1) begin n_fail++; $display("FAIL div_wrap_busy cyc%0d got %b exp 1", c, chk_stall); end
      n_tests++;
      if (wb_en !== (c == 9)) begin n_fail++; $display("FAIL div_wb_en cyc%0d got %b exp %b", c, wb_en, c == 9); end
      if (c == 9) begin
        n_tests++;
        if (wb_fd !== 5'd31 || wb_dbl !== 1'b1 || fpu_op !== 2'b11) begin
          n_fail++; $display("FAIL div_wb_fd got fd=%0d dbl=%b op=%0d exp fd=31 dbl=1 op=3", wb_fd, wb_dbl, fpu_op);
        end
      end
      adv();
    end
    @(negedge clk);
    n_tests++;
    if (req_stall !== 1'b0 || fpu_start !== 1'b1 || chk_stall !== 1'b0) begin
      n_fail++; $display("FAIL div_next_accept got st=%b fs=%b cs=%b exp st=0 fs=1 cs=0", req_stall, fpu_start, chk_stall);
    end
    adv();
    drain();
  endtask

  task automatic test_lat1();
    rst_n = 0; model_reset(); adv(); rst_n = 1; adv();
    req_valid = 1; req_op = 2'b00; req_dbl = 0; req_fd = 5'd7;
    @(negedge clk);
    n_tests++;
    if (fpu_start_1 !== 1'b1) begin n_fail++; $display("FAIL lat1_start0 got %b exp 1", fpu_start_1); end
    adv();
    req_fd = 5'd8;
    @(negedge clk);
    n_tests++;
    if (wb_en_1 !== 1'b1 || wb_fd_1 !== 5'd7 || req_stall_1 !== 1'b1 || fpu_start_1 !== 1'b0) begin
      n_fail++; $display("FAIL lat1_wb1 got wb=%b fd=%0d st=%b fs=%b exp wb=1 fd=7 st=1 fs=0",
        wb_en_1, wb_fd_1, req_stall_1, fpu_start_1);
    end
    adv();
    @(negedge clk);
    n_tests++;
    if (wb_en_1 !== 1'b0 || req_stall_1 !== 1'b0 || fpu_start_1 !== 1'b1) begin
      n_fail++; $display("FAIL lat1_accept2 got wb=%b st=%b fs=%b exp wb=0 st=0 fs=1", wb_en_1, req_stall_1, fpu_start_1);
    end
    adv();
    req_valid = 0;
    @(negedge clk);
    n_tests++;
    if (wb_en_1 !== 1'b1 || wb_fd_1 !== 5'd8) begin
      n_fail++; $display("FAIL lat1_wb3 got wb=%b fd=%0d exp wb=1 fd=8", wb_en_1, wb_fd_1);
    end
    adv();
    drain();
  endtask

  task automatic issue_add(input logic [4:0] fd, input logic [7:0] st, input logic clr_at_wb);
    req_valid = 1; req_op = 2'b00; req_dbl = 0; req_fd = fd; fpu_status = st;
    adv();
    req_valid = 0;
    adv();
    clr_flags = clr_at_wb;
    adv();
    clr_flags = 0;
  endtask

  task automatic test_sticky();
    clr_flags = 1; adv(); clr_flags = 0;
    issue_add(5'd1, 8'h04, 1'b0);
    @(negedge clk);
    n_tests++;
    if (sticky_flags !== 8'h04) begin n_fail++; $display("FAIL sticky_first got %h exp 04", sticky_flags); end
    issue_add(5'd2, 8'h10, 1'b0);
    @(negedge clk);
    n_tests++;
    if (sticky_flags !== 8'h14) begin n_fail++; $display("FAIL sticky_accum got %h exp 14", sticky_flags); end
    issue_add(5'd3, 8'h01, 1'b1);
    @(negedge clk);
    n_tests++;
    if (sticky_flags !== 8'h00) begin n_fail++; $display("FAIL sticky_clr_prio got %h exp 00", sticky_flags); end
    drain();
  endtask

  task automatic test_reset_midop();
    issue_add(5'd6, 8'h20, 1'b0);
    req_valid = 1; req_op = 2'b10; req_dbl = 0; req_fd = 5'd10; fpu_status = 8'h08;
    adv();
    req_valid = 0; chk_rd_en = 1; chk_rd_a = 5'd10; chk_rd_b = 5'd10;
    adv();
    rst_n = 0; model_reset();
    @(negedge clk);
    n_tests++;
    if (wb_en !== 1'b0 || chk_stall !== 1'b0 || sticky_flags !== 8'h00 || fpu_op !== 2'b00 || wb_fd !== 5'd0) begin
      n_fail++; $display("FAIL midrst_clear got wb=%b cs=%b sf=%h op=%0d fd=%0d exp all 0",
        wb_en, chk_stall, sticky_flags, fpu_op, wb_fd);
    end
    adv();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (wb_en !== 1'b0 || chk_stall !== 1'b0) begin
        n_fail++; $display("FAIL midrst_no_wb cyc%0d got wb=%b cs=%b exp 0 0", c, wb_en, chk_stall);
      end
      adv();
    end
    chk_rd_en = 0; req_valid = 1; req_op = 2'b00; req_fd = 5'd5;
    @(negedge clk);
    n_tests++;
    if (fpu_start !== 1'b1 || req_stall !== 1'b0) begin
      n_fail++; $display("FAIL midrst_accept got fs=%b st=%b exp fs=1 st=0", fpu_start, req_stall);
    end
    adv();
    drain();
  endtask

  task automatic test_random();
    bit hold;
    bit ewb;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (!(req_valid && hold)) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_op    = 2'($urandom_range(0, 3));
        req_dbl   = 1'($urandom_range(0, 1));
        req_fd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      end
      chk_rd_en  = !req_valid && ($urandom_range(0, 1) == 1);
      chk_wr_en  = !req_valid && ($urandom_range(0, 2) == 0);
      chk_rd_a   = 5'($urandom_range(0, 7));
      chk_rd_b   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      chk_wr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      fpu_status = 8'($urandom);
      clr_flags  = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      ewb = m_active && (m_left == 0);
      n_tests++;
      if (req_stall !== (req_valid && m_active) || fpu_start !== (req_valid && !m_active)) begin
        n_fail++; $display("FAIL rnd_handshake cyc%0d got st=%b fs=%b exp st=%b fs=%b",
          c, req_stall, fpu_start, req_valid && m_active, req_valid && !m_active);
      end
      n_tests++;
      if (chk_stall !== e_chk()) begin n_fail++; $display("FAIL rnd_chk_stall cyc%0d got %b exp %b", c, chk_stall, e_chk()); end
      n_tests++;
      if (wb_en !== ewb) begin n_fail++; $display("FAIL rnd_wb_en cyc%0d got %b exp %b", c, wb_en, ewb); end
      n_tests++;
      if (wb_fd !== m_fd || wb_dbl !== m_dbl || fpu_op !== m_op || fpu_dbl !== m_dbl) begin
        n_fail++; $display("FAIL rnd_regs cyc%0d got fd=%0d dbl=%b op=%0d exp fd=%0d dbl=%b op=%0d",
          c, wb_fd, wb_dbl, fpu_op, m_fd, m_dbl, m_op);
      end
      n_tests++;
      if (sticky_flags !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky cyc%0d got %h exp %h", c, sticky_flags, m_sticky); end
      hold = req_valid && m_active;
      adv();
    end
    drain();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_add();
    test_double_div();
    test_lat1();
    test_sticky();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
